// File: rtl/test_reporter.sv
// Self-test result reporter: counts steps, records the first failure, latches the verdict and drives the pass/fail LEDs.
// Optional blink-code failure display is enabled with TEST_REPORTER_BLINK_EN; without it, red is lit steadily on failure.
module test_reporter #(
    parameter int BLINK_CYC = 25000000,
    parameter int PAUSE_CYC = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       test_step,
    input  logic       test_good,
    input  logic       test_ended,
    output logic [7:0] step_count,
    output logic [7:0] fail_step,
    output logic       done,
    output logic       led_g,
    output logic       led_r
);

    if (BLINK_CYC < 1 || PAUSE_CYC < 1) begin : g_cfg_err
        $error("test_reporter: BLINK_CYC and PAUSE_CYC must be at least 1");
    end

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_FAIL_ON = 3'd2;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] step_nxt;
    logic [7:0] fail_nxt;

    // Counters only move while the test is running; the verdict uses the updated values.
    always_comb begin
        step_nxt = step_count;
        fail_nxt = fail_step;
        if (state == ST_RUN && test_step) begin
            step_nxt = (step_count == 8'hff) ? 8'hff : step_count + 8'd1;
            if (!test_good && fail_step == 8'd0) begin
                fail_nxt = step_nxt;
            end
        end
    end

`ifdef TEST_REPORTER_BLINK_EN
    localparam logic [2:0]  ST_FAIL_OFF   = 3'd3;
    localparam logic [2:0]  ST_FAIL_PAUSE = 3'd4;
    localparam logic [26:0] BLINK_LAST    = 27'(BLINK_CYC - 1);
    localparam logic [26:0] PAUSE_LAST    = 27'(PAUSE_CYC - 1);

    logic [26:0] phase;
    logic [3:0]  blinks;
    logic [3:0]  n_blinks;

    assign n_blinks = (fail_step > 8'd15) ? 4'd15 : fail_step[3:0];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (test_ended) begin
                    state_nxt = (fail_nxt == 8'd0) ? ST_PASS : ST_FAIL_ON;
                end
            end
            ST_PASS: state_nxt = ST_PASS;
            ST_FAIL_ON: begin
                if (phase == BLINK_LAST) begin
                    state_nxt = ST_FAIL_OFF;
                end
            end
            ST_FAIL_OFF: begin
                if (phase == BLINK_LAST) begin
                    state_nxt = (blinks < n_blinks) ? ST_FAIL_ON : ST_FAIL_PAUSE;
                end
            end
            ST_FAIL_PAUSE: begin
                if (phase == PAUSE_LAST) begin
                    state_nxt = ST_FAIL_ON;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // blinks counts completed on-phases within the current group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 27'd0;
            blinks <= 4'd0;
        end else begin
            if (state_nxt != state || state == ST_RUN || state == ST_PASS) begin
                phase <= 27'd0;
            end else begin
                phase <= phase + 27'd1;
            end
            if (state == ST_FAIL_ON && state_nxt == ST_FAIL_OFF) begin
                blinks <= blinks + 4'd1;
            end else if (state == ST_FAIL_PAUSE && state_nxt == ST_FAIL_ON) begin
                blinks <= 4'd0;
            end
        end
    end
`else
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (test_ended) begin
                    state_nxt = (fail_nxt == 8'd0) ? ST_PASS : ST_FAIL_ON;
                end
            end
            ST_PASS:    state_nxt = ST_PASS;
            ST_FAIL_ON: state_nxt = ST_FAIL_ON;
            default:    state_nxt = ST_RUN;
        endcase
    end
`endif

    // LEDs and done are registered from the next state so they rise on the verdict edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            step_count <= 8'd0;
            fail_step  <= 8'd0;
            done       <= 1'b0;
            led_g      <= 1'b0;
            led_r      <= 1'b0;
        end else begin
            state      <= state_nxt;
            step_count <= step_nxt;
            fail_step  <= fail_nxt;
            done       <= (state_nxt != ST_RUN);
            led_g      <= (state_nxt == ST_PASS);
            led_r      <= (state_nxt == ST_FAIL_ON);
        end
    end

endmodule

// File: tb/tb_test_reporter.sv
// Scoreboard bench for test_reporter: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_test_reporter;

    localparam int B = 4;
    localparam int P = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       test_step = 1'b0;
    logic       test_good = 1'b1;
    logic       test_ended = 1'b0;
    logic [7:0] step_count;
    logic [7:0] fail_step;
    logic       done;
    logic       led_g;
    logic       led_r;

    int vectors = 0;
    int miscompares = 0;

    test_reporter #(.BLINK_CYC(B), .PAUSE_CYC(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .test_step  (test_step),
        .test_good  (test_good),
        .test_ended (test_ended),
        .step_count (step_count),
        .fail_step  (fail_step),
        .done       (done),
        .led_g      (led_g),
        .led_r      (led_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] sc;
        logic [7:0] fs;
        logic       dn;
        logic       g;
        logic       r;
    } exp_t;

    exp_t exp_q[$];

    task automatic push(input string nm, input logic [7:0] sc, input logic [7:0] fs,
                        input logic dn, input logic g, input logic r);
        exp_t e;
        e.name = nm;
        e.sc = sc;
        e.fs = fs;
        e.dn = dn;
        e.g = g;
        e.r = r;
        exp_q.push_back(e);
    endtask

    // Expected red LED k cycles after the verdict edge, for a failing step count n.
    function automatic logic exp_r(input int k, input int n);
`ifdef TEST_REPORTER_BLINK_EN
        int nb;
        int per;
        int p;
        nb  = (n > 15) ? 15 : n;
        per = 2 * nb * B + P;
        p   = k % per;
        return (p < 2 * nb * B) && ((p % (2 * B)) < B);
`else
        return (n > 0) && (k >= 0);
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (step_count !== e.sc || fail_step !== e.fs || done !== e.dn ||
                led_g !== e.g || led_r !== e.r) begin
                miscompares++;
                $display("FAIL %s: got sc=%0d fs=%0d done=%0b g=%0b r=%0b, want sc=%0d fs=%0d done=%0b g=%0b r=%0b",
                         e.name, step_count, fail_step, done, led_g, led_r,
                         e.sc, e.fs, e.dn, e.g, e.r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic step(input logic good);
        test_step = 1'b1;
        test_good = good;
        tick();
        test_step = 1'b0;
        test_good = 1'b1;
    endtask

    task automatic end_test();
        test_ended = 1'b1;
        tick();
        test_ended = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick();
        tick();
        push("reset", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // Pass run: six good steps
        for (int i = 0; i < 6; i++) step(1'b1);
        push("pass_pre", 8'd6, 8'd0, 1'b0, 1'b0, 1'b0);
        end_test();
        for (int i = 0; i < 200; i++) begin
            push("pass_hold", 8'd6, 8'd0, 1'b1, 1'b1, 1'b0);
            tick();
        end

        // Fail run: good, good, bad, bad
        do_reset();
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        push("fail_pre", 8'd4, 8'd3, 1'b0, 1'b0, 1'b0);
        end_test();
        for (int k = 0; k < 80; k++) begin
            push("fail3_led", 8'd4, 8'd3, 1'b1, 1'b0, exp_r(k, 3));
            tick();
        end

        // Fail at step 2
        do_reset();
        step(1'b1);
        step(1'b0);
        end_test();
        for (int k = 0; k < 200; k++) begin
            push("fail2_led", 8'd2, 8'd2, 1'b1, 1'b0, exp_r(k, 2));
            tick();
        end

        // Saturation, then a late failure
        do_reset();
        test_step = 1'b1;
        test_good = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        test_step = 1'b0;
        push("sat_count", 8'd255, 8'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0);
        push("sat_fail", 8'd255, 8'd255, 1'b0, 1'b0, 1'b0);
        end_test();
        for (int k = 0; k < 140; k++) begin
            push("fail15_led", 8'd255, 8'd255, 1'b1, 1'b0, exp_r(k, 255));
            tick();
        end

        // Bad step in the same cycle as test_ended, then activity after done
        do_reset();
        step(1'b1);
        step(1'b1);
        test_step = 1'b1;
        test_good = 1'b0;
        test_ended = 1'b1;
        tick();
        push("same_cycle", 8'd3, 8'd3, 1'b1, 1'b0, 1'b1);
        test_step = 1'b1;
        test_good = 1'b0;
        tick();
        test_step = 1'b0;
        test_good = 1'b1;
        test_ended = 1'b0;
        push("after_done", 8'd3, 8'd3, 1'b1, 1'b0, 1'b1);
        tick();

        // Asynchronous reset while led_r is lit, checked before the next clock edge
        rst_n = 1'b0;
        #1;
        if (step_count !== 8'd0 || fail_step !== 8'd0 || done !== 1'b0 ||
            led_g !== 1'b0 || led_r !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_immediate: got sc=%0d fs=%0d done=%0b g=%0b r=%0b, want all 0",
                     step_count, fail_step, done, led_g, led_r);
        end
        push("rst_async", 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        step(1'b1);
        step(1'b1);
        end_test();
        push("post_rst_pass", 8'd2, 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        if (led_g !== 1'b1 || led_r !== 1'b0) begin
            miscompares++;
            $display("FAIL post_rst_leds: got g=%0b r=%0b, want g=1 r=0", led_g, led_r);
        end
        tick();

        if (vectors == 0) begin
            miscompares++;
            $display("FAIL scoreboard: got 0 vectors, want more than 0");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
